// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and instruction memory (slave).
// A request is held until the memory answers with imem_valid; imem_rdata is valid in that cycle.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_valid;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a time,
// and feeds a registered IF/ID latch with a one-entry skid buffer for decode stalls.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  OP_BITS     = 6,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    fetch_unit_if.master           imem,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [OP_BITS-1:0]     if_opcode
);

    typedef enum logic [1:0] {
        START    = 2'd0,
        FETCH    = 2'd1,
        KILL     = 2'd2,
        BUFFERED = 2'd3
    } state_t;

    state_t                 state_reg,     state_next;
    logic [PC_WIDTH-1:0]    pc_reg,        pc_next;
    logic [PC_WIDTH-1:0]    kill_addr_reg, kill_addr_next;
    logic                   if_valid_reg,  if_valid_next;
    logic [INSTR_WIDTH-1:0] if_instr_reg,  if_instr_next;
    logic [PC_WIDTH-1:0]    if_pc_reg,     if_pc_next;
    logic                   buf_valid_reg, buf_valid_next;
    logic [INSTR_WIDTH-1:0] buf_instr_reg, buf_instr_next;
    logic [PC_WIDTH-1:0]    buf_pc_reg,    buf_pc_next;
    logic [PC_WIDTH-1:0]    pc_inc;

    assign pc_inc = pc_reg + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // In KILL the abandoned request is still in flight, so its address must stay on the bus.
    assign imem.imem_req  = (state_reg == FETCH) || (state_reg == KILL);
    assign imem.imem_addr = (state_reg == KILL) ? kill_addr_reg : pc_reg;

    assign if_valid  = if_valid_reg;
    assign if_instr  = if_instr_reg;
    assign if_pc     = if_pc_reg;
    assign if_opcode = if_instr_reg[INSTR_WIDTH-1 -: OP_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= START;
            pc_reg        <= RESET_PC;
            kill_addr_reg <= RESET_PC;
            if_valid_reg  <= 1'b0;
            if_instr_reg  <= '0;
            if_pc_reg     <= '0;
            buf_valid_reg <= 1'b0;
            buf_instr_reg <= '0;
            buf_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            kill_addr_reg <= kill_addr_next;
            if_valid_reg  <= if_valid_next;
            if_instr_reg  <= if_instr_next;
            if_pc_reg     <= if_pc_next;
            buf_valid_reg <= buf_valid_next;
            buf_instr_reg <= buf_instr_next;
            buf_pc_reg    <= buf_pc_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        kill_addr_next = kill_addr_reg;
        if_valid_next  = if_valid_reg;
        if_instr_next  = if_instr_reg;
        if_pc_next     = if_pc_reg;
        buf_valid_next = buf_valid_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc_next    = buf_pc_reg;

        // Decode consumes IF/ID on every unstalled cycle; a refill below re-raises it.
        if (!stall) begin
            if_valid_next = 1'b0;
        end

        unique case (state_reg)
            START: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem.imem_valid) begin
                    if (!redirect) begin
                        if (!stall) begin
                            if_valid_next = 1'b1;
                            if_instr_next = imem.imem_rdata;
                            if_pc_next    = pc_reg;
                        end else begin
                            buf_valid_next = 1'b1;
                            buf_instr_next = imem.imem_rdata;
                            buf_pc_next    = pc_reg;
                            state_next     = BUFFERED;
                        end
                        pc_next = pc_inc;
                    end
                end else if (redirect) begin
                    kill_addr_next = pc_reg;
                    state_next     = KILL;
                end
            end
            KILL: begin
                if (imem.imem_valid) begin
                    state_next = FETCH;
                end
            end
            BUFFERED: begin
                if (!stall) begin
                    if_valid_next  = buf_valid_reg;
                    if_instr_next  = buf_instr_reg;
                    if_pc_next     = buf_pc_reg;
                    buf_valid_next = 1'b0;
                    state_next     = FETCH;
                end
            end
            default: begin
                state_next = START;
            end
        endcase

        // Redirect wins over stall and over a same-cycle completion.
        if (redirect) begin
            if_valid_next  = 1'b0;
            buf_valid_next = 1'b0;
            pc_next        = redirect_pc;
            if (state_reg == BUFFERED) begin
                state_next = FETCH;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus randomized
// stall/redirect/latency traffic checked by a program-order delivery model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [5:0]  if_opcode;

    logic        rst1_n;
    logic        stall1;
    logic        redirect1;
    logic [3:0]  redirect_pc1;
    logic        if_valid1;
    logic [31:0] if_instr1;
    logic [3:0]  if_pc1;
    logic [5:0]  if_opcode1;

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;
    int fixed_lat = 0;   // negative selects a random latency per request

    fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) bus0 ();
    fetch_unit_if #(.PC_WIDTH(4),  .INSTR_WIDTH(32)) bus1 ();

    fetch_unit #(.PC_WIDTH(16), .INSTR_WIDTH(32), .OP_BITS(6), .RESET_PC(16'd0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus0),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_opcode   (if_opcode)
    );

    fetch_unit #(.PC_WIDTH(4), .INSTR_WIDTH(32), .OP_BITS(6), .RESET_PC(4'd14)) dut1 (
        .clk         (clk),
        .rst_n       (rst1_n),
        .stall       (stall1),
        .redirect    (redirect1),
        .redirect_pc (redirect_pc1),
        .imem        (bus1),
        .if_valid    (if_valid1),
        .if_instr    (if_instr1),
        .if_pc       (if_pc1),
        .if_opcode   (if_opcode1)
    );

    // Memory contents: opcode field carries the low address bits, low bits repeat the address.
    function automatic logic [31:0] word0(input logic [15:0] a);
        return {a[5:0], 10'h000, a};
    endfunction

    function automatic logic [31:0] word1(input logic [3:0] a);
        return {2'b00, a, 22'h000000, a};
    endfunction

    // Small PC_WIDTH instance sees a zero-wait memory.
    assign bus1.imem_valid = bus1.imem_req;
    assign bus1.imem_rdata = word1(bus1.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Variable-latency memory for the main instance; answers cur_lat cycles after a request appears.
    initial begin
        int cnt;
        int cur_lat;
        bit req_d;
        cnt = 0;
        cur_lat = 0;
        req_d = 1'b0;
        bus0.imem_valid = 1'b0;
        bus0.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus0.imem_valid || !req_d) cnt = 0;
            else cnt++;
            if (cnt == 0) cur_lat = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
            req_d = bus0.imem_req;
            bus0.imem_valid = bus0.imem_req && (cnt >= cur_lat);
            bus0.imem_rdata = bus0.imem_valid ? word0(bus0.imem_addr) : 32'hDEAD_BEEF;
        end
    end

    // Reference model: decode must receive consecutive PCs in program order, restarting at each
    // redirect target; stalls freeze IF/ID; a redirect empties it; the read address never moves mid-request.
    initial begin
        logic [15:0] exp_pc;
        bit          have_prev;
        logic        p_stall, p_redirect, p_valid, p_req, p_mvalid;
        logic [15:0] p_pc, p_addr;
        logic [31:0] p_instr;
        exp_pc = 16'd0;
        have_prev = 1'b0;
        {p_stall, p_redirect, p_valid, p_req, p_mvalid} = '0;
        p_pc = '0;
        p_addr = '0;
        p_instr = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                exp_pc = 16'd0;
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    if (p_redirect) begin
                        check("flush_valid", {31'b0, if_valid}, 32'd0);
                    end else if (p_stall) begin
                        check("hold_valid", {31'b0, if_valid}, {31'b0, p_valid});
                        if (p_valid) begin
                            check("hold_pc", {16'b0, if_pc}, {16'b0, p_pc});
                            check("hold_instr", if_instr, p_instr);
                        end
                    end
                    if (p_req && !p_mvalid) begin
                        check("req_held", {31'b0, bus0.imem_req}, 32'd1);
                        check("addr_stable", {16'b0, bus0.imem_addr}, {16'b0, p_addr});
                    end
                end
                if (if_valid) begin
                    check("instr_data", if_instr, word0(if_pc));
                    check("opcode", {26'b0, if_opcode}, {26'b0, if_pc[5:0]});
                end
                if (redirect) begin
                    exp_pc = redirect_pc;
                end else if (if_valid && !stall) begin
                    $display("deliver pc=%04h instr=%08h op=%02h", if_pc, if_instr, if_opcode);
                    check("order_pc", {16'b0, if_pc}, {16'b0, exp_pc});
                    exp_pc = exp_pc + 16'd1;
                    n_deliv++;
                end
                p_stall = stall;
                p_redirect = redirect;
                p_valid = if_valid;
                p_pc = if_pc;
                p_instr = if_instr;
                p_req = bus0.imem_req;
                p_mvalid = bus0.imem_valid;
                p_addr = bus0.imem_addr;
                have_prev = 1'b1;
            end
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    // Holds the main instance in reset, checks reset outputs, then releases just after an edge.
    task automatic reset0(input int lat);
        next_edge();
        #1;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        fixed_lat = lat;
        repeat (2) next_edge();
        @(negedge clk);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_req", {31'b0, bus0.imem_req}, 32'd0);
        check("rst_addr", {16'b0, bus0.imem_addr}, 32'd0);
        check("rst_pc", {16'b0, if_pc}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_opcode", {26'b0, if_opcode}, 32'd0);
        next_edge();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int deliv_start;
        logic [3:0] e1;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        rst1_n = 1'b0;
        stall1 = 1'b0;
        redirect1 = 1'b0;
        redirect_pc1 = '0;

        // Zero-wait streaming right after reset.
        reset0(0);
        @(negedge clk);
        check("start_req", {31'b0, bus0.imem_req}, 32'd0);
        check("start_valid", {31'b0, if_valid}, 32'd0);
        next_edge();
        @(negedge clk);
        check("first_req", {31'b0, bus0.imem_req}, 32'd1);
        check("first_valid", {31'b0, if_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_edge();
            @(negedge clk);
            check("zw_valid", {31'b0, if_valid}, 32'd1);
            check("zw_pc", {16'b0, if_pc}, i);
            check("zw_opcode", {26'b0, if_opcode}, i);
        end

        // Three-cycle memory, then a redirect to 0x40 while the pc=5 read is outstanding.
        reset0(2);
        @(negedge clk);
        for (int k = 1; k <= 22; k++) begin
            next_edge();
            if (k == 16) begin
                redirect = 1'b1;
                redirect_pc = 16'h0040;
            end
            if (k == 17) redirect = 1'b0;
            @(negedge clk);
            if (k <= 16) begin
                check("lat3_req", {31'b0, bus0.imem_req}, 32'd1);
                check("lat3_addr", {16'b0, bus0.imem_addr}, (k - 1) / 3);
                check("lat3_valid", {31'b0, if_valid}, {31'b0, (k >= 4) && ((k - 4) % 3 == 0)});
                if ((k >= 4) && ((k - 4) % 3 == 0)) check("lat3_pc", {16'b0, if_pc}, (k - 4) / 3);
            end else if (k <= 18) begin
                check("kill_addr", {16'b0, bus0.imem_addr}, 32'd5);
                check("kill_valid", {31'b0, if_valid}, 32'd0);
            end else if (k <= 21) begin
                check("redir_addr", {16'b0, bus0.imem_addr}, 32'h40);
                check("redir_req", {31'b0, bus0.imem_req}, 32'd1);
                check("redir_valid", {31'b0, if_valid}, 32'd0);
            end else begin
                check("redir_ifv", {31'b0, if_valid}, 32'd1);
                check("redir_pc", {16'b0, if_pc}, 32'h40);
            end
        end

        // Four-cycle stall while streaming from zero-wait memory.
        reset0(0);
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            next_edge();
            if (k == 4) stall = 1'b1;
            if (k == 8) stall = 1'b0;
            @(negedge clk);
            if (k >= 2 && k <= 4) check("pre_stall_pc", {16'b0, if_pc}, k - 2);
            if (k >= 5 && k <= 8) begin
                check("stall_pc", {16'b0, if_pc}, 32'd2);
                check("stall_valid", {31'b0, if_valid}, 32'd1);
                check("stall_req", {31'b0, bus0.imem_req}, 32'd0);
            end
            if (k == 9) begin
                check("unstall_pc", {16'b0, if_pc}, 32'd3);
                check("unstall_req", {31'b0, bus0.imem_req}, 32'd1);
                check("unstall_addr", {16'b0, bus0.imem_addr}, 32'd4);
            end
            if (k == 10) check("post_stall_pc", {16'b0, if_pc}, 32'd4);
        end

        // Redirect with stall and a full buffer, then redirect coinciding with a completion.
        reset0(0);
        @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            next_edge();
            if (k == 3) stall = 1'b1;
            if (k == 5) begin
                redirect = 1'b1;
                redirect_pc = 16'h0020;
            end
            if (k == 6) begin
                redirect = 1'b0;
                stall = 1'b0;
            end
            if (k == 7) begin
                redirect = 1'b1;
                redirect_pc = 16'h0030;
            end
            if (k == 8) redirect = 1'b0;
            @(negedge clk);
            if (k == 4) begin
                check("buf_full_pc", {16'b0, if_pc}, 32'd1);
                check("buf_full_req", {31'b0, bus0.imem_req}, 32'd0);
            end
            if (k == 6) begin
                check("rs_valid", {31'b0, if_valid}, 32'd0);
                check("rs_addr", {16'b0, bus0.imem_addr}, 32'h20);
                check("rs_req", {31'b0, bus0.imem_req}, 32'd1);
            end
            if (k == 7) check("rs_pc", {16'b0, if_pc}, 32'h20);
            if (k == 8) begin
                check("rv_valid", {31'b0, if_valid}, 32'd0);
                check("rv_addr", {16'b0, bus0.imem_addr}, 32'h30);
            end
            if (k == 9) begin
                check("rv_ifv", {31'b0, if_valid}, 32'd1);
                check("rv_pc", {16'b0, if_pc}, 32'h30);
            end
        end

        // Narrow PC: wrap from 15 to 0, then an asynchronous reset in the middle of a fetch.
        repeat (2) next_edge();
        #1;
        rst1_n = 1'b1;
        @(negedge clk);
        check("n_start_req", {31'b0, bus1.imem_req}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            next_edge();
            @(negedge clk);
            if (k >= 2) begin
                e1 = 4'd14 + 4'(k - 2);
                check("wrap_valid", {31'b0, if_valid1}, 32'd1);
                check("wrap_pc", {28'b0, if_pc1}, {28'b0, e1});
                check("wrap_opcode", {26'b0, if_opcode1}, {28'b0, e1});
            end
        end
        next_edge();
        rst1_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, if_valid1}, 32'd0);
        check("mid_rst_req", {31'b0, bus1.imem_req}, 32'd0);
        check("mid_rst_addr", {28'b0, bus1.imem_addr}, 32'd14);
        next_edge();
        #1;
        rst1_n = 1'b1;
        @(negedge clk);
        check("restart_req0", {31'b0, bus1.imem_req}, 32'd0);
        next_edge();
        @(negedge clk);
        check("restart_addr", {28'b0, bus1.imem_addr}, 32'd14);
        next_edge();
        @(negedge clk);
        check("restart_pc", {28'b0, if_pc1}, 32'd14);
        check("restart_valid", {31'b0, if_valid1}, 32'd1);

        // Random stall, redirect and memory latency, checked by the delivery model.
        reset0(-1);
        deliv_start = n_deliv;
        for (int c = 0; c < 800; c++) begin
            next_edge();
            stall = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFD + 16'($urandom_range(0, 2));
            else redirect_pc = 16'($urandom);
        end
        next_edge();
        stall = 1'b0;
        redirect = 1'b0;
        repeat (10) next_edge();
        @(negedge clk);
        check("progress", {31'b0, (n_deliv - deliv_start) >= 60}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with a registered IF/ID output. It owns the program counter and issues word-addressed reads to instruction memory over a valid/req handshake with variable latency. It presents the fetched instruction, its PC and the extracted opcode to the decode stage, where the opcode feeds the control decoder. It honours decode-stage stalls and redirects the PC on taken branches and jumps, discarding wrong-path fetches.

## Interface
- PC_WIDTH, 16, program counter / instruction memory word-address width
- INSTR_WIDTH, 32, instruction word width
- OP_BITS, 6, opcode width; opcode = instr[INSTR_WIDTH-1 -: OP_BITS]
- RESET_PC, 0, first fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept; IF/ID must hold
- redirect  in  1  taken branch/jump; flush and refetch from redirect_pc
- redirect_pc  in  PC_WIDTH  redirect target (word address)
- imem_req  out  1  read request
- imem_addr  out  PC_WIDTH  read address; stable while imem_req high
- imem_valid  in  1  read complete this cycle (only meaningful while imem_req high)
- imem_rdata  in  INSTR_WIDTH  read data, valid with imem_valid
- if_valid  out  1  IF/ID holds a real instruction
- if_instr  out  INSTR_WIDTH  IF/ID instruction
- if_pc  out  PC_WIDTH  address of if_instr
- if_opcode  out  OP_BITS  opcode field of if_instr, to control decoder

## Operation
- States: START, FETCH, KILL, BUFFERED.
- Reset (async): state=START, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, buf_valid=0. Outputs: imem_req=0, imem_addr=RESET_PC, if_opcode=0.
- imem_req=1 in FETCH and KILL; 0 in START and BUFFERED. imem_addr=pc.
- START -> FETCH unconditionally (one idle cycle after reset release). If redirect is high in START, pc<=redirect_pc.
- FETCH, imem_valid=0: hold. If redirect: pc<=redirect_pc, -> KILL. The request can't be aborted, so addr stays on the old pc. Keep the old address in a separate register, or delay the pc update; either way imem_addr must stay stable.
- FETCH, imem_valid=1, no redirect, stall=0: IF/ID<= (rdata, pc), if_valid<=1, pc<=pc+1, stay FETCH.
- FETCH, imem_valid=1, no redirect, stall=1: IF/ID holds. Capture (rdata, pc) into the one-entry skid buffer, pc<=pc+1, -> BUFFERED.
- KILL, imem_valid=1: discard data, -> FETCH at the redirect target. A new redirect in KILL updates the target and stays in KILL.
- BUFFERED, stall=0: IF/ID<=buffer, if_valid<=1, buf_valid<=0, -> FETCH.
- Redirect in any state: if_valid<=0, buf_valid<=0. Redirect takes priority over stall and over completion; completion data in the same cycle is dropped.
- Stall=1 with no redirect: if_valid, if_instr and if_pc hold unchanged.
- PC increment wraps modulo 2^PC_WIDTH (max -> 0).
- At most one outstanding request; no speculative fetch beyond the skid buffer.

## Timing
- Zero-wait memory (imem_valid same cycle as req): sustained one instruction per cycle. if_valid rises one cycle after the completing edge.
- N-cycle memory: one instruction per N cycles. Completion to if_valid is 1 cycle.
- Reset release to first imem_req: 1 cycle (START). To first if_valid with zero-wait memory: 2 cycles.
- Redirect to imem_addr=redirect_pc: next cycle if no request is outstanding. If one is outstanding, the cycle after its imem_valid.
- Stall release from BUFFERED: buffered instruction appears in IF/ID at the next edge; new fetch starts that same cycle.
- Reset asserted mid-transaction returns immediately to the reset state. A late imem_valid is ignored because imem_req=0 in START.

## Test plan
- Reset, zero-wait memory returning instr=addr<<26: if_pc sequence 0,1,2,3 on consecutive cycles; if_opcode=0,1,2,3; first if_valid 2 cycles after rst_n rises.
- 3-cycle memory latency: imem_addr stable for 3 cycles per request; if_valid pulses once every 3 cycles; pc increments by 1 per completion.
- stall=1 for 4 cycles during streaming: if_instr/if_pc frozen; exactly one fetch buffered, imem_req=0; on release the buffered pc appears next, with no skipped or duplicated pc.
- redirect to 0x40 while a 3-cycle fetch of pc=5 is outstanding: addr stays 5 until valid, data dropped, if_valid=0, next request addr=0x40, next if_pc=0x40.
- redirect and stall together with the buffer full: if_valid=0, buffer cleared, next fetch is redirect_pc; redirect in the same cycle as imem_valid drops the data.
- PC_WIDTH=4, RESET_PC=14: if_pc sequence 14,15,0,1; rst_n pulsed low mid-fetch gives immediate if_valid=0, imem_req=0, restart at 14.
